video_source_mux: RTL and testbench



---
 rtl/video_source_mux.sv | 177 +++++++++++++++++
 tb/tb_video_source_mux.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/video_source_mux.sv
// Frame-synchronous pixel source select with colour-mode transform and optional multi-frame crossfade.
// Fixed 3-cycle latency from src_rgb/pix_valid to out_rgb/out_valid; no backpressure (pixel-clock streaming).
module video_source_mux #(
  parameter int NUM_SRC = 8,
  parameter int CW = 4,
  parameter int SEL_W = 3,
  parameter int FADE_LOG2 = 2,
  parameter logic [3*CW-1:0] BG_RGB = '1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC*3*CW-1:0]  src_rgb,
  input  logic                     pix_valid,
  input  logic                     frame_start,
  input  logic [SEL_W-1:0]         req_sel,
  input  logic [2:0]               req_mode,
  input  logic                     fade_en,
  output logic [3*CW-1:0]          out_rgb,
  output logic                     out_valid,
  output logic [SEL_W-1:0]         active_sel,
  output logic                     switch_pending,
  output logic                     fading
);

  localparam int PW = 3 * CW;
  localparam int S = 1 << FADE_LOG2;
  localparam int KW = (FADE_LOG2 > 0) ? FADE_LOG2 : 1;
  localparam int FW = CW + FADE_LOG2 + 1;
  localparam logic [KW-1:0] K_LAST = KW'(S - 1);

  typedef enum logic {IDLE, FADE} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] prev_sel, active_sel_d, prev_sel_d;
  logic [2:0]       active_mode, active_mode_d;
  logic [KW-1:0]    k_q, k_d;

  logic [PW-1:0]    new_sel_px, old_sel_px;
  logic [PW-1:0]    s1_new, s1_old, s2_new, s2_old, mix_px;
  logic [2:0]       s1_mode;
  logic             s1_fade, s2_fade, s1_vld, s2_vld;
  logic [KW-1:0]    s1_k, s2_k;

  function automatic logic [PW-1:0] apply_mode(input logic [2:0] mode, input logic [PW-1:0] px);
    logic [CW-1:0] r, g, b;
    logic [CW+1:0] sum;
    r = px[PW-1 -: CW];
    g = px[2*CW-1 -: CW];
    b = px[CW-1:0];
    sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    case (mode)
      3'd0:    apply_mode = px;
      3'd1:    apply_mode = {3{sum[CW+1:2]}};
      3'd2:    apply_mode = {b, g, r};
      3'd3:    apply_mode = ~px;
      default: apply_mode = BG_RGB;
    endcase
  endfunction

  // Weighted mix of one component; the result is the (old*(S-k) + new*k) >> FADE_LOG2 slice.
  function automatic logic [CW-1:0] blend(input logic [CW-1:0] o, input logic [CW-1:0] n,
                                          input logic [KW-1:0] k);
    logic [FW-1:0] wk, wo, acc;
    wk = FW'(k);
    wo = FW'(S) - wk;
    acc = FW'(o) * wo + FW'(n) * wk;
    blend = acc[FADE_LOG2 +: CW];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      active_sel  <= '0;
      prev_sel    <= '0;
      active_mode <= '0;
      k_q         <= '0;
    end else begin
      state_q     <= state_d;
      active_sel  <= active_sel_d;
      prev_sel    <= prev_sel_d;
      active_mode <= active_mode_d;
      k_q         <= k_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    active_sel_d  = active_sel;
    prev_sel_d    = prev_sel;
    active_mode_d = active_mode;
    k_d           = k_q;
    if (frame_start) begin
      active_mode_d = req_mode;
      case (state_q)
        IDLE: begin
          if (req_sel != active_sel) begin
            active_sel_d = req_sel;
            if (fade_en && FADE_LOG2 > 0) begin
              prev_sel_d = active_sel;
              k_d        = KW'(1);
              state_d    = FADE;
            end
          end
        end
        FADE: begin
          // A new request mid-fade restarts the blend from the currently shown target.
          if (req_sel != active_sel) begin
            prev_sel_d   = active_sel;
            active_sel_d = req_sel;
            k_d          = KW'(1);
          end else if (k_q == K_LAST) begin
            state_d = IDLE;
            k_d     = '0;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign fading         = (state_q == FADE);
  assign switch_pending = (req_sel != active_sel) || (req_mode != active_mode);

  always_comb begin
    new_sel_px = BG_RGB;
    old_sel_px = BG_RGB;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (active_sel == SEL_W'(i)) new_sel_px = src_rgb[i*PW +: PW];
      if (prev_sel == SEL_W'(i))   old_sel_px = src_rgb[i*PW +: PW];
    end
  end

  always_comb begin
    mix_px = s2_new;
    if (s2_fade) begin
      for (int c = 0; c < 3; c++) begin
        mix_px[c*CW +: CW] = blend(s2_old[c*CW +: CW], s2_new[c*CW +: CW], s2_k);
      end
    end
  end

  // Mode and fade weight travel with the pixel so a frame_start mid-pipeline never splits a pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_new    <= '0;
      s1_old    <= '0;
      s1_mode   <= '0;
      s1_fade   <= 1'b0;
      s1_k      <= '0;
      s1_vld    <= 1'b0;
      s2_new    <= '0;
      s2_old    <= '0;
      s2_fade   <= 1'b0;
      s2_k      <= '0;
      s2_vld    <= 1'b0;
      out_rgb   <= '0;
      out_valid <= 1'b0;
    end else begin
      s1_new    <= new_sel_px;
      s1_old    <= old_sel_px;
      s1_mode   <= active_mode;
      s1_fade   <= (state_q == FADE);
      s1_k      <= k_q;
      s1_vld    <= pix_valid;
      s2_new    <= apply_mode(s1_mode, s1_new);
      s2_old    <= apply_mode(s1_mode, s1_old);
      s2_fade   <= s1_fade;
      s2_k      <= s1_k;
      s2_vld    <= s1_vld;
      out_rgb   <= s2_vld ? mix_px : '0;
      out_valid <= s2_vld;
    end
  end

endmodule

// File: tb/tb_video_source_mux.sv
// Scoreboard bench: driver predicts each visible pixel from a frame-level model; monitor pops and compares.
module tb_video_source_mux;

  localparam int NUM_SRC = 4;
  localparam int CW = 4;
  localparam int SEL_W = 3;
  localparam int FADE_LOG2 = 2;
  localparam int S = 4;
  localparam int PW = 12;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_SRC*PW-1:0]   src_rgb;
  logic                    pix_valid;
  logic                    frame_start;
  logic [SEL_W-1:0]        req_sel;
  logic [2:0]              req_mode;
  logic                    fade_en;
  logic [PW-1:0]           out_rgb;
  logic                    out_valid;
  logic [SEL_W-1:0]        active_sel;
  logic                    switch_pending;
  logic                    fading;

  logic [PW-1:0] src [NUM_SRC];
  logic [PW-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  bit started = 0;

  // Model: selected source, faded-from source, mode, and fade frame index (0 = not fading).
  int m_active, m_prev, m_mode, m_k;

  always #5 clk = ~clk;

  always_comb begin
    src_rgb = '0;
    for (int i = 0; i < NUM_SRC; i++) src_rgb[i*PW +: PW] = src[i];
  end

  video_source_mux #(
    .NUM_SRC(NUM_SRC), .CW(CW), .SEL_W(SEL_W), .FADE_LOG2(FADE_LOG2), .BG_RGB(12'hfff)
  ) dut (
    .clk(clk), .rst(rst), .src_rgb(src_rgb), .pix_valid(pix_valid),
    .frame_start(frame_start), .req_sel(req_sel), .req_mode(req_mode), .fade_en(fade_en),
    .out_rgb(out_rgb), .out_valid(out_valid), .active_sel(active_sel),
    .switch_pending(switch_pending), .fading(fading)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] pick(input int sel);
    return (sel < NUM_SRC) ? src[sel] : 12'hfff;
  endfunction

  function automatic logic [PW-1:0] xform(input int mode, input logic [PW-1:0] p);
    logic [3:0] r, g, b, y;
    r = p[11:8];
    g = p[7:4];
    b = p[3:0];
    y = 4'((int'(r) + 2 * int'(g) + int'(b)) / 4);
    case (mode)
      0: return p;
      1: return {y, y, y};
      2: return {b, g, r};
      3: return ~p;
      default: return 12'hfff;
    endcase
  endfunction

  function automatic logic [PW-1:0] mix(input logic [PW-1:0] o, input logic [PW-1:0] n, input int k);
    logic [PW-1:0] res;
    res = '0;
    for (int c = 0; c < 3; c++) begin
      res[c*4 +: 4] = 4'((int'(o[c*4 +: 4]) * (S - k) + int'(n[c*4 +: 4]) * k) / S);
    end
    return res;
  endfunction

  // One pixel-clock cycle: predict the pixel entering now, then advance the model at the edge.
  task automatic step(input bit fs, input bit pv);
    logic [PW-1:0] n, o;
    frame_start = fs;
    pix_valid = pv;
    if (pv) begin
      n = xform(m_mode, pick(m_active));
      o = xform(m_mode, pick(m_prev));
      exp_q.push_back((m_k != 0) ? mix(o, n, m_k) : n);
    end
    @(posedge clk);
    #1;
    if (fs) begin
      m_mode = int'(req_mode);
      if (int'(req_sel) != m_active) begin
        if (m_k != 0 || fade_en) begin
          m_prev = m_active;
          m_k = 1;
        end
        m_active = int'(req_sel);
      end else if (m_k != 0) begin
        m_k = (m_k + 1) % S;
      end
    end
  endtask

  task automatic frame(input int len);
    step(1'b1, 1'b1);
    repeat (len - 1) step(1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    frame_start = 1'b0;
    pix_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_active = 0;
    m_prev = 0;
    m_mode = 0;
    m_k = 0;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_fading", int'(fading), 0);
    chk("rst_active_sel", int'(active_sel), 0);
    chk("rst_out_rgb", int'(out_rgb), 0);
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("active_sel", int'(active_sel), m_active);
      chk("fading", int'(fading), int'(m_k != 0));
      chk("switch_pending", int'(switch_pending),
          int'(int'(req_sel) != m_active || int'(req_mode) != m_mode));
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_valid_unexpected actual=1 expected=0 at %0t", $time);
        end else begin
          logic [PW-1:0] e;
          e = exp_q.pop_front();
          checks--;
          chk("out_rgb", int'(out_rgb), int'(e));
        end
      end else begin
        chk("blank_rgb", int'(out_rgb), 0);
      end
    end
  end

  initial begin
    src[0] = 12'h000;
    src[1] = 12'hf00;
    src[2] = 12'h0f0;
    src[3] = 12'h00f;
    req_sel = '0;
    req_mode = '0;
    fade_en = 1'b0;
    do_reset();
    started = 1;

    // Request without frame_start: pending, still source 0.
    req_sel = 3'd2;
    repeat (6) step(1'b0, 1'b1);
    // Hard cut to source 1.
    req_sel = 3'd1;
    frame(8);
    frame(6);
    // Crossfade 1 -> 3 over four frames.
    fade_en = 1'b1;
    req_sel = 3'd3;
    repeat (5) frame(7);
    // Back to source 1, then exercise each mode and an out-of-range select.
    fade_en = 1'b0;
    req_sel = 3'd1;
    frame(6);
    req_mode = 3'd1; frame(6);
    req_mode = 3'd3; frame(6);
    req_mode = 3'd2; frame(6);
    req_mode = 3'd0; req_sel = 3'd5; frame(6);
    req_sel = 3'd1; frame(6);
    // Valid gaps propagate as blanking.
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0);
    // Reset in the second frame of a fade.
    fade_en = 1'b1;
    req_sel = 3'd2;
    frame(6);
    frame(3);
    do_reset();
    req_sel = 3'd0;
    frame(6);
    frame(6);

    // Randomised traffic with random sources, requests and occasional resets.
    begin
      int left;
      left = 0;
      for (int n = 0; n < 4000; n++) begin
        for (int i = 0; i < NUM_SRC; i++) src[i] = PW'($urandom_range(0, 4095));
        if ($urandom_range(0, 5) == 0) req_sel = SEL_W'($urandom_range(0, 7) > 5 ? $urandom_range(4, 7) : $urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) req_mode = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 7) == 0) fade_en = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 499) == 0) begin
          do_reset();
          left = 0;
        end else if (left == 0) begin
          step(1'b1, 1'($urandom_range(0, 1)));
          left = $urandom_range(3, 12);
        end else begin
          step(1'b0, 1'($urandom_range(0, 3) != 0));
          left--;
        end
      end
    end

    repeat (5) step(1'b0, 1'b0);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
